// File: rtl/cordic_arbiter.sv
// Round-robin front end that time-shares one iterative cordic core between NREQ requesters.
// One operation in flight: grant, clear the core, run until done or watchdog, hold the result.
module cordic_arbiter #(
    parameter int BITWIDTH = 16,
    parameter int NREQ     = 4,
    parameter int TIMEOUT  = 64,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BITWIDTH-1:0] req_angle,
    output logic [NREQ-1:0]          req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [IDW-1:0]           res_id,
    output logic [BITWIDTH-1:0]      res_x,
    output logic [BITWIDTH-1:0]      res_y,
    output logic                     res_err,
    output logic                     busy,
    output logic                     core_rst,
    output logic                     core_en,
    output logic [BITWIDTH-1:0]      core_angle,
    input  logic [BITWIDTH-1:0]      core_x,
    input  logic [BITWIDTH-1:0]      core_y,
    input  logic                     core_done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StClear, StRun, StResult} state_e;

    state_e              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [BITWIDTH-1:0] angle_q, angle_d;
    logic [BITWIDTH-1:0] x_q, x_d;
    logic [BITWIDTH-1:0] y_q, y_d;
    logic                err_q, err_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                any_valid;
    logic [IDW-1:0]      winner;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_valid && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                any_valid = 1'b1;
                winner    = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        angle_d   = angle_q;
        x_d       = x_q;
        y_d       = y_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        req_ready[winner] = 1'b1;
                        angle_d = req_angle[int'(winner)*BITWIDTH +: BITWIDTH];
                        id_d    = winner;
                        ptr_d   = IDW'((int'(winner) + 1) % NREQ);
                        state_d = StClear;
                    end
                end
                StClear: begin
                    cnt_d   = '0;
                    state_d = StRun;
                end
                StRun: begin
                    cnt_d = cnt_q + 1'b1;
                    // Done takes precedence over a coincident watchdog expiry.
                    if (core_done) begin
                        x_d     = core_x;
                        y_d     = core_y;
                        err_d   = 1'b0;
                        state_d = StResult;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        x_d     = '0;
                        y_d     = '0;
                        err_d   = 1'b1;
                        state_d = StResult;
                    end
                end
                StResult: begin
                    if (res_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            id_q    <= '0;
            angle_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            angle_q <= angle_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign res_valid  = (state_q == StResult);
    assign core_rst   = rst | (state_q == StClear);
    assign core_en    = en & (state_q == StRun);
    assign core_angle = angle_q;
    assign res_id     = id_q;
    assign res_x      = x_q;
    assign res_y      = y_q;
    assign res_err    = err_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: stub core with programmable done latency, directed table,
// hand sequences for reset/enable/idle-done, and a randomized run against a reference model.
module tb_cordic_arbiter;

    localparam int BW   = 16;
    localparam int NREQ = 4;
    localparam int TO   = 64;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst, en, res_ready, res_valid, res_err, busy;
    logic              core_rst, core_en, core_done;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*BW-1:0] req_angle;
    logic [IDW-1:0]    res_id;
    logic [BW-1:0]     res_x, res_y, core_angle, core_x, core_y;

    int checks = 0;
    int failures = 0;

    // Stub core: done on its stub_d-th enabled cycle after core_rst; stub_d == 0 never finishes.
    int         stub_d = 0;
    logic       done_force = 1'b0;
    logic [7:0] stub_cnt;

    always @(posedge clk) begin
        if (core_rst) stub_cnt <= 8'd0;
        else if (core_en) stub_cnt <= stub_cnt + 8'd1;
    end
    assign core_done = done_force | (stub_d != 0 && int'(stub_cnt) == stub_d - 1);
    assign core_x    = core_angle + 16'd1;
    assign core_y    = core_angle ^ 16'hA5A5;

    always #5 clk = ~clk;

    cordic_arbiter #(.BITWIDTH(BW), .NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_x(res_x), .res_y(res_y), .res_err(res_err), .busy(busy),
        .core_rst(core_rst), .core_en(core_en), .core_angle(core_angle),
        .core_x(core_x), .core_y(core_y), .core_done(core_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ang_of(input logic [15:0] base, input int i);
        return base + 16'(i) * 16'h1111;
    endfunction

    task automatic set_angles(input logic [15:0] base);
        for (int i = 0; i < NREQ; i++) req_angle[i*BW +: BW] = ang_of(base, i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One full transaction starting in IDLE. gap: en low for that many cycles from cycle 4.
    task automatic run_op(input logic [3:0] mask, input logic [15:0] base, input int d,
                          input int hold, input int gap, output int id, output int lat,
                          output logic [15:0] rx, output logic [15:0] ry, output logic rerr,
                          output int encnt);
        logic [15:0] ang;
        int          c;
        bit          done, bad_ready, bad_angle, bad_hold;
        stub_d = d;
        set_angles(base);
        req_valid = mask;
        res_ready = 1'b0;
        en = 1'b1;
        #1;
        id = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
        check("grant_onehot", 64'($countones(req_ready)), 64'd1);
        ang = (id >= 0) ? ang_of(base, id) : 16'h0;
        c = 0; encnt = 0; lat = -1; done = 0; bad_ready = 0; bad_angle = 0; bad_hold = 0;
        while (!done && c < 300) begin
            tick();
            c++;
            req_valid = '0;
            en = !(gap > 0 && c >= 4 && c < 4 + gap);
            #1;
            if (c == 1) check("core_rst_in_clear", core_rst, 1);
            if (res_valid) begin
                lat = c;
                done = 1;
            end else begin
                if (req_ready != 0) bad_ready = 1;
                if (core_en) begin
                    encnt++;
                    if (core_angle != ang) bad_angle = 1;
                end
            end
        end
        en = 1'b1;
        check("result_within_bound", done, 1);
        check("no_ready_while_busy", bad_ready, 0);
        check("core_angle_stable", bad_angle, 0);
        rx = res_x; ry = res_y; rerr = res_err;
        check("res_id", res_id, id);
        req_valid = 4'hF;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (!res_valid || res_x != rx || res_y != ry || res_err != rerr ||
                res_id != IDW'(id) || req_ready != 0 || !busy) bad_hold = 1;
        end
        check("backpressure_stable", bad_hold, 0);
        res_ready = 1'b1;
        #1;
        check("no_grant_at_handshake", req_ready, 0);
        tick();
        req_valid = '0;
        res_ready = 1'b0;
        #1;
        check("idle_after_handshake", {res_valid, busy}, 2'b00);
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] base;
        int          d;
        int          hold;
        int          exp_id;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int id, lat, encnt, model_ptr, m_id, m_lat, m_en, d, hold, gap;
        logic [15:0] rx, ry, base, m_ang;
        logic rerr, m_err, bad;
        logic [3:0] mask;

        vecs[0] = '{4'b0100, 16'hFDDE, 15, 0,  2, 17, 1'b0};
        vecs[1] = '{4'b0101, 16'h1234, 3,  10, 0, 5,  1'b0};
        vecs[2] = '{4'b0101, 16'h4000, 5,  0,  2, 7,  1'b0};
        vecs[3] = '{4'b1111, 16'h8001, 1,  2,  3, 3,  1'b0};
        vecs[4] = '{4'b1000, 16'h0F0F, 0,  0,  3, 66, 1'b1};
        vecs[5] = '{4'b0011, 16'h7777, 64, 0,  0, 66, 1'b0};
        vecs[6] = '{4'b0011, 16'h0000, 2,  0,  1, 4,  1'b0};

        rst = 1'b1; en = 1'b1; req_valid = '0; req_angle = '0; res_ready = 1'b0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_res_data", {res_x, res_y, res_id, res_err}, '0);
        check("reset_core_en", core_en, 0);
        check("reset_core_rst", core_rst, 1);
        check("reset_req_ready", req_ready, 0);
        rst = 1'b0;
        tick();

        // Directed table from pointer 0
        foreach (vecs[i]) begin
            run_op(vecs[i].mask, vecs[i].base, vecs[i].d, vecs[i].hold, 0,
                   id, lat, rx, ry, rerr, encnt);
            check($sformatf("vec%0d_id", i), 64'(id), 64'(vecs[i].exp_id));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_err", i), rerr, vecs[i].exp_err);
            m_ang = ang_of(vecs[i].base, vecs[i].exp_id);
            check($sformatf("vec%0d_x", i), rx, vecs[i].exp_err ? 16'h0 : m_ang + 16'd1);
            check($sformatf("vec%0d_y", i), ry, vecs[i].exp_err ? 16'h0 : m_ang ^ 16'hA5A5);
            check($sformatf("vec%0d_core_en_cycles", i), 64'(encnt),
                  64'(vecs[i].d == 0 ? TO : vecs[i].d));
        end

        // Enable held low 5 cycles mid-RUN stretches latency by exactly 5
        run_op(4'b0010, 16'h3000, 10, 0, 5, id, lat, rx, ry, rerr, encnt);
        check("en_gap_id", 64'(id), 64'd1);
        check("en_gap_latency", 64'(lat), 64'd17);
        check("en_gap_core_en_cycles", 64'(encnt), 64'd10);

        // Reset mid-RUN: discard op, pointer back to 0
        stub_d = 30;
        set_angles(16'h5000);
        req_valid = 4'b0100;
        #1;
        check("pre_reset_grant", req_ready, 4'b0100);
        for (int k = 0; k < 5; k++) begin
            tick();
            req_valid = '0;
        end
        check("pre_reset_running", core_en, 1);
        rst = 1'b1;
        #1;
        check("rst_drives_core_rst", core_rst, 1);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (busy || res_valid) bad = 1;
        end
        check("reset_discards_op", bad, 0);
        run_op(4'hF, 16'h6000, 4, 0, 0, id, lat, rx, ry, rerr, encnt);
        check("post_reset_grant_id", 64'(id), 64'd0);

        // core_done while idle is ignored
        done_force = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (busy || res_valid) bad = 1;
        end
        done_force = 1'b0;
        check("idle_done_ignored", bad, 0);

        // Fairness after reset: all held valid, strict rotation
        do_reset();
        for (int k = 0; k < 8; k++) begin
            run_op(4'hF, 16'h0100 * 16'(k), 1 + k, 0, 0, id, lat, rx, ry, rerr, encnt);
            check($sformatf("fair%0d_id", k), 64'(id), 64'(k % NREQ));
        end

        // Randomized against the reference model
        do_reset();
        model_ptr = 0;
        for (int n = 0; n < 40; n++) begin
            mask = 4'($urandom_range(1, 15));
            base = 16'($urandom);
            d    = ($urandom_range(0, 7) == 0) ? 64 : int'($urandom_range(0, 22));
            hold = int'($urandom_range(0, 3));
            gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            m_id = -1;
            for (int k = 0; k < NREQ; k++)
                if (m_id < 0 && mask[(model_ptr + k) % NREQ]) m_id = (model_ptr + k) % NREQ;
            model_ptr = (m_id + 1) % NREQ;
            m_err = (d == 0 || d > TO);
            m_en  = m_err ? TO : d;
            m_lat = m_en + 2;
            if (m_lat > 4) m_lat += gap;
            m_ang = ang_of(base, m_id);
            run_op(mask, base, d, hold, gap, id, lat, rx, ry, rerr, encnt);
            check($sformatf("rnd%0d_id", n), 64'(id), 64'(m_id));
            check($sformatf("rnd%0d_latency", n), 64'(lat), 64'(m_lat));
            check($sformatf("rnd%0d_err", n), rerr, m_err);
            check($sformatf("rnd%0d_xy", n), {rx, ry},
                  m_err ? 32'h0 : {m_ang + 16'd1, m_ang ^ 16'hA5A5});
            check($sformatf("rnd%0d_core_en_cycles", n), 64'(encnt), 64'(m_en));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
